// File: rtl/simd_iter_divider.sv
// ----------------------------------------------------------------------------
// simd_iter_divider
//   Multi-cycle signed integer divider for one SIMD lane. It uses a restoring
//   algorithm that produces one quotient bit per clock. Divide-by-zero and
//   MIN/-1 overflow give saturated results and bypass the iteration.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   in_valid     dividend/divisor valid (sampled only while in_ready=1)
//   in_ready     high in IDLE: an operation can be accepted
//   dividend     signed numerator
//   divisor      signed denominator
//   flush        synchronous abort; has priority over accept and out_ready
//   out_valid    result valid (high in DONE)
//   out_ready    consumer accepts the result
//   quotient     signed quotient, truncated toward zero
//   remainder    signed remainder, takes the sign of the dividend
//   div_by_zero  status flag, qualified by out_valid
//   overflow     status flag, qualified by out_valid
// ----------------------------------------------------------------------------
module simd_iter_divider #(
  parameter int BIT_WIDTH = 32,
  parameter int CNT_BITS  = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] dividend,
  input  logic [BIT_WIDTH-1:0] divisor,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] quotient,
  output logic [BIT_WIDTH-1:0] remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam logic [BIT_WIDTH-1:0] MAX_POS  = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic [BIT_WIDTH-1:0] MIN_NEG  = {1'b1, {(BIT_WIDTH-1){1'b0}}};
  localparam logic [BIT_WIDTH-1:0] MINUS_1  = {BIT_WIDTH{1'b1}};
  localparam logic [CNT_BITS-1:0]  CNT_INIT = CNT_BITS'(BIT_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [CNT_BITS-1:0]    cnt_reg, cnt_next;
  logic [BIT_WIDTH-1:0]   rem_reg, rem_next;     // partial remainder magnitude
  logic [BIT_WIDTH-1:0]   quo_reg, quo_next;     // dividend shifts out, quotient shifts in
  logic [BIT_WIDTH-1:0]   dvsr_reg, dvsr_next;   // |divisor|
  logic                   neg_q_reg, neg_q_next;
  logic                   neg_r_reg, neg_r_next;
  logic [BIT_WIDTH-1:0]   quotient_reg, quotient_next;
  logic [BIT_WIDTH-1:0]   remainder_reg, remainder_next;
  logic                   dbz_reg, dbz_next;
  logic                   ovf_reg, ovf_next;

  logic [BIT_WIDTH-1:0]   abs_dividend, abs_divisor;
  logic [BIT_WIDTH:0]     shifted_rem, trial;
  logic [BIT_WIDTH-1:0]   quo_neg, rem_neg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dvsr_reg      <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rem_reg       <= rem_next;
      quo_reg       <= quo_next;
      dvsr_reg      <= dvsr_next;
      neg_q_reg     <= neg_q_next;
      neg_r_reg     <= neg_r_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
      ovf_reg       <= ovf_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    rem_next       = rem_reg;
    quo_next       = quo_reg;
    dvsr_next      = dvsr_reg;
    neg_q_next     = neg_q_reg;
    neg_r_next     = neg_r_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;
    ovf_next       = ovf_reg;

    // |MIN| wraps to 2^(BIT_WIDTH-1), which is still correct as an unsigned magnitude.
    abs_dividend = dividend[BIT_WIDTH-1] ? (~dividend + 1'b1) : dividend;
    abs_divisor  = divisor[BIT_WIDTH-1]  ? (~divisor + 1'b1)  : divisor;

    // The partial remainder is always below |divisor| <= 2^(BIT_WIDTH-1), so
    // after the shift it fits in BIT_WIDTH bits. The extra MSB of the trial
    // result is its sign.
    shifted_rem = {rem_reg, quo_reg[BIT_WIDTH-1]};
    trial       = shifted_rem - {1'b0, dvsr_reg};

    quo_neg = ~quo_reg + 1'b1;
    rem_neg = ~rem_reg + 1'b1;

    if (flush) begin
      // Abort: the data outputs keep their old value and the flags drop.
      state_next = IDLE;
      dbz_next   = 1'b0;
      ovf_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            neg_q_next = dividend[BIT_WIDTH-1] ^ divisor[BIT_WIDTH-1];
            neg_r_next = dividend[BIT_WIDTH-1];
            dvsr_next  = abs_divisor;
            quo_next   = abs_dividend;
            rem_next   = '0;
            cnt_next   = CNT_INIT;
            if (divisor == '0) begin
              quotient_next  = dividend[BIT_WIDTH-1] ? MIN_NEG : MAX_POS;
              remainder_next = dividend;
              dbz_next       = 1'b1;
              state_next     = DONE;
            end else if (dividend == MIN_NEG && divisor == MINUS_1) begin
              quotient_next  = MAX_POS;
              remainder_next = '0;
              ovf_next       = 1'b1;
              state_next     = DONE;
            end else begin
              state_next = CALC;
            end
          end
        end
        CALC: begin
          if (!trial[BIT_WIDTH]) begin
            rem_next = trial[BIT_WIDTH-1:0];
            quo_next = {quo_reg[BIT_WIDTH-2:0], 1'b1};
          end else begin
            rem_next = shifted_rem[BIT_WIDTH-1:0];
            quo_next = {quo_reg[BIT_WIDTH-2:0], 1'b0};
          end
          if (cnt_reg == '0) begin
            state_next = FIX;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        FIX: begin
          quotient_next  = neg_q_reg ? quo_neg : quo_reg;
          remainder_next = neg_r_reg ? rem_neg : rem_reg;
          state_next     = DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_next = IDLE;
            dbz_next   = 1'b0;
            ovf_next   = 1'b0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;
  assign overflow    = ovf_reg;

endmodule

// File: tb/tb_simd_iter_divider.sv
// ----------------------------------------------------------------------------
// tb_simd_iter_divider
//   Scoreboard bench: every accepted operation pushes its expected result,
//   computed with plain signed arithmetic, and a monitor pops and compares
//   on each output handshake. Directed cases come first, then random ones.
// ----------------------------------------------------------------------------
module tb_simd_iter_divider;
  localparam int BW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] dividend;
  logic [BW-1:0] divisor;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] quotient;
  logic [BW-1:0] remainder;
  logic          div_by_zero;
  logic          overflow;

  always #5 clk = ~clk;

  simd_iter_divider #(.BIT_WIDTH(BW), .CNT_BITS(6)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  typedef struct {
    logic [BW-1:0] a, b, q, r;
    logic          dbz, ovf;
  } exp_t;

  exp_t scb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: the language's own signed division truncates toward
  // zero and gives the remainder the dividend's sign.
  function automatic exp_t model(input logic [BW-1:0] a, input logic [BW-1:0] b);
    exp_t   e;
    longint sa, sb;
    sa    = longint'(signed'(a));
    sb    = longint'(signed'(b));
    e.a   = a;
    e.b   = b;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (sb == 0) begin
      e.q   = (sa >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      e.r   = a;
      e.dbz = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q   = 32'h7FFF_FFFF;
      e.r   = '0;
      e.ovf = 1'b1;
    end else begin
      e.q = 32'(sa / sb);
      e.r = 32'(sa % sb);
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        if (scb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got q=%h r=%h with empty scoreboard", quotient, remainder);
        end else begin
          e = scb.pop_front();
          if ({quotient, remainder, div_by_zero, overflow} !== {e.q, e.r, e.dbz, e.ovf}) begin
            errors++;
            $display("FAIL result %h/%h: got q=%h r=%h dbz=%b ovf=%b expected q=%h r=%h dbz=%b ovf=%b",
                     e.a, e.b, quotient, remainder, div_by_zero, overflow, e.q, e.r, e.dbz, e.ovf);
          end else begin
            $display("ok %h / %h -> q=%h r=%h dbz=%b ovf=%b",
                     e.a, e.b, quotient, remainder, div_by_zero, overflow);
          end
        end
      end
    end
  endtask

  // Called at a negedge; returns at posedge+1 just after the accept edge.
  task automatic accept(input logic [BW-1:0] a, input logic [BW-1:0] b, input bit push);
    bit got = 0;
    for (int k = 0; k < 200; k++) begin
      if (in_ready) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
    end
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    if (push) scb.push_back(model(a, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // One full operation. stall > 0 keeps out_ready low for that many cycles
  // after out_valid and checks that the result is held. Ends at a negedge.
  task automatic do_op(input logic [BW-1:0] a, input logic [BW-1:0] b, input int stall);
    exp_t          e;
    int            lat = 0;
    int            ir_bad = 0;
    int            unstable = 0;
    bit            got = 0;
    logic [65:0]   snap;
    e = model(a, b);
    if (stall > 0) out_ready = 1'b0;
    accept(a, b, 1'b1);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; break; end
      if (in_ready) ir_bad++;
      lat++;
    end
    chk("valid_seen", 64'(got), 64'd1);
    chk("latency_edges", 64'(lat), (e.dbz || e.ovf) ? 64'd0 : 64'(BW + 1));
    chk("in_ready_low_busy", 64'(ir_bad + int'(in_ready)), 64'd0);
    if (stall > 0) begin
      snap = {quotient, remainder, div_by_zero, overflow};
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        if ({quotient, remainder, div_by_zero, overflow} !== snap || !out_valid || in_ready)
          unstable++;
      end
      chk("held_while_stalled", 64'(unstable), 64'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    chk("handshake_done", {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    int quiet;
    logic [BW-1:0] ra, rb;
    reset     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_flags", {62'd0, div_by_zero, overflow}, 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed sign and special cases.
    do_op(32'd100, 32'd7, 0);
    do_op(-32'sd100, 32'd7, 0);
    do_op(32'd100, -32'sd7, 0);
    do_op(-32'sd100, -32'sd7, 0);
    do_op(32'd5, 32'd0, 0);
    do_op(-32'sd5, 32'd0, 0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(32'h8000_0000, 32'd1, 0);
    do_op(32'd7, -32'sd9, 0);

    // Stalled consumer, then back-to-back operation.
    do_op(32'd50, 32'd3, 10);
    do_op(32'd1000, 32'd10, 0);

    // Reset during CALC loses the result and clears the outputs at once.
    accept(32'd12345, 32'd67, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midreset_quotient", 64'(quotient), 64'd0);
    chk("midreset_remainder", 64'(remainder), 64'd0);
    chk("midreset_status", {61'd0, out_valid, div_by_zero, overflow}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_op(32'd9, 32'd3, 0);

    // Flush during CALC: back to IDLE, old data kept, no result produced.
    accept(32'd77, 32'd5, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_keeps_data", {quotient, remainder}, {32'd3, 32'd0});
    quiet = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) quiet++;
    end
    chk("flush_no_result", 64'(quiet), 64'd0);

    // Random operations, with occasional consumer stalls.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom_range(0, 2000) - 1000; rb = $urandom_range(0, 40) - 20; end
        2: begin ra = $urandom; rb = '0; end
        3: begin ra = 32'h8000_0000; rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom; end
        4: begin ra = $urandom; rb = $urandom_range(1, 300) - 150; end
        default: begin rb = $urandom; ra = rb >> $urandom_range(1, 8); end
      endcase
      do_op(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    chk("scoreboard_drained", 64'(scb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
